// File: rtl/bru_pkg.sv
// Shared encodings and the saturating-counter helper for the branch resolve unit.
package bru_pkg;

    typedef enum logic [1:0] {
        PCSRC_SEQ   = 2'b00,
        PCSRC_TGT   = 2'b01,
        PCSRC_JALR  = 2'b10,
        PCSRC_RECOV = 2'b11
    } pcsrc_e;

    typedef enum logic [2:0] {
        BR_BEQ  = 3'b000,
        BR_BNE  = 3'b001,
        BR_BLT  = 3'b100,
        BR_BGE  = 3'b101,
        BR_BLTU = 3'b110,
        BR_BGEU = 3'b111
    } branch_op_e;

    typedef enum logic [1:0] {
        JT_NONE = 2'b00,
        JT_JAL  = 2'b01,
        JT_JALR = 2'b10,
        JT_RSVD = 2'b11
    } jump_type_e;

    localparam logic [1:0] BHT_CNT_RESET = 2'b01;

    function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
        logic [1:0] res;
        if (taken) begin
            res = (cnt == 2'b11) ? 2'b11 : cnt + 2'b01;
        end else begin
            res = (cnt == 2'b00) ? 2'b00 : cnt - 2'b01;
        end
        return res;
    endfunction

endpackage

// File: rtl/bht_table.sv
// Array of 2-bit saturating counters: one combinational read port, one
// trained write port, asynchronous reset to weakly-not-taken.
module bht_table
    import bru_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [1:0]       rd_cnt_o,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic             wr_taken_i
);

    logic [ENTRIES-1:0][1:0] cnt_q;
    logic [ENTRIES-1:0][1:0] cnt_d;

    // Next-state: only the addressed counter moves when training.
    always_comb begin
        cnt_d = cnt_q;
        if (wr_en_i) begin
            cnt_d[wr_idx_i] = sat_update(cnt_q[wr_idx_i], wr_taken_i);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= {ENTRIES{BHT_CNT_RESET}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Read returns the pre-update value even when the same index is written.
    assign rd_cnt_o = cnt_q[rd_idx_i];

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolution with a bimodal/gshare BHT and fetch lookup.
// Optional perf counters are built when BRU_PERF_CNT_EN is defined.
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int INDEX_MODE  = 0,
    parameter int GHR_W       = 6,
    parameter int CNT_W       = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] PCF,
    output logic            PredTakenF,
    input  logic            ValidE,
    input  logic            StallE,
    input  logic [XLEN-1:0] PCE,
    input  logic            BranchE,
    input  logic [2:0]      BranchOpE,
    input  logic [1:0]      JumpTypeE,
    input  logic            ZeroE,
    input  logic            LtE,
    input  logic            LtuE,
    input  logic            PredTakenE,
    output logic [1:0]      PCSrcE,
`ifdef BRU_PERF_CNT_EN
    output logic            FlushE,
    output logic [CNT_W-1:0] BranchCntO,
    output logic [CNT_W-1:0] MispredCntO
`else
    output logic            FlushE
`endif
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic [GHR_W-1:0] ghr_q;
    logic [GHR_W-1:0] ghr_d;
    logic [IDX_W-1:0] rd_idx_s;
    logic [IDX_W-1:0] wr_idx_s;
    logic [1:0]       rd_cnt_s;
    logic             taken_s;
    logic             is_jump_s;
    logic             upd_en_s;
    pcsrc_e           pcsrc_s;
    logic             flush_s;
    logic             unused_s;

    function automatic logic [IDX_W-1:0] bht_index(input logic [XLEN-1:0] pc,
                                                   input logic [GHR_W-1:0] ghr);
        logic [IDX_W-1:0] idx;
        idx = pc[IDX_W+1:2];
        if (INDEX_MODE == 1) begin
            idx[GHR_W-1:0] = idx[GHR_W-1:0] ^ ghr;
        end
        return idx;
    endfunction

    assign rd_idx_s   = bht_index(PCF, ghr_q);
    assign wr_idx_s   = bht_index(PCE, ghr_q);
    assign PredTakenF = rd_cnt_s[1];

    // Branch condition from ALU flags; undefined funct3 resolves not-taken.
    always_comb begin
        taken_s = 1'b0;
        case (BranchOpE)
            BR_BEQ:  taken_s = ZeroE;
            BR_BNE:  taken_s = ~ZeroE;
            BR_BLT:  taken_s = LtE;
            BR_BGE:  taken_s = ~LtE;
            BR_BLTU: taken_s = LtuE;
            BR_BGEU: taken_s = ~LtuE;
            default: taken_s = 1'b0;
        endcase
    end

    assign is_jump_s = (JumpTypeE == JT_JAL) || (JumpTypeE == JT_JALR);
    assign upd_en_s  = ValidE & BranchE & ~is_jump_s & ~StallE;

    // Priority resolution of PC select and flush; jumps outrank branches.
    always_comb begin
        pcsrc_s = PCSRC_SEQ;
        flush_s = 1'b0;
        if (!ValidE) begin
            pcsrc_s = PCSRC_SEQ;
            flush_s = 1'b0;
        end else if (JumpTypeE == JT_JAL) begin
            pcsrc_s = PCSRC_TGT;
            flush_s = 1'b1;
        end else if (JumpTypeE == JT_JALR) begin
            pcsrc_s = PCSRC_JALR;
            flush_s = 1'b1;
        end else if (BranchE) begin
            if (taken_s && !PredTakenE) begin
                pcsrc_s = PCSRC_TGT;
                flush_s = 1'b1;
            end else if (!taken_s && PredTakenE) begin
                pcsrc_s = PCSRC_RECOV;
                flush_s = 1'b1;
            end else begin
                pcsrc_s = PCSRC_SEQ;
                flush_s = 1'b0;
            end
        end else begin
            pcsrc_s = PCSRC_SEQ;
            flush_s = 1'b0;
        end
    end

    assign PCSrcE = pcsrc_s;
    assign FlushE = flush_s;

    // Global history shifts in each trained outcome.
    always_comb begin
        if (upd_en_s) begin
            ghr_d = GHR_W'({ghr_q, taken_s});
        end else begin
            ghr_d = ghr_q;
        end
    end

    // Global history register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end

    bht_table #(
        .ENTRIES (BHT_ENTRIES),
        .IDX_W   (IDX_W)
    ) u_bht (
        .clk        (clk),
        .rst        (rst),
        .rd_idx_i   (rd_idx_s),
        .rd_cnt_o   (rd_cnt_s),
        .wr_en_i    (upd_en_s),
        .wr_idx_i   (wr_idx_s),
        .wr_taken_i (taken_s)
    );

`ifdef BRU_PERF_CNT_EN
    // Resolved-branch and mispredict counters, wrapping naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            BranchCntO  <= '0;
            MispredCntO <= '0;
        end else if (upd_en_s) begin
            BranchCntO  <= BranchCntO + {{(CNT_W-1){1'b0}}, 1'b1};
            MispredCntO <= MispredCntO + {{(CNT_W-1){1'b0}}, flush_s};
        end else begin
            BranchCntO  <= BranchCntO;
            MispredCntO <= MispredCntO;
        end
    end
`endif

    assign unused_s = ^{PCF[XLEN-1:IDX_W+2], PCF[1:0], PCE[XLEN-1:IDX_W+2], PCE[1:0],
                        rd_cnt_s[0], (CNT_W > 0)};

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench: a driver applies directed vectors and queues the
// hand-computed response; a negedge monitor pops and compares.
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    // Instance A: bimodal defaults.  Instance B: gshare, GHR_W=2.
    logic [31:0] a_pcf, a_pce, b_pcf, b_pce;
    logic        a_valid, a_stall, a_branch, a_zero, a_lt, a_ltu, a_pe;
    logic        b_valid, b_stall, b_branch, b_zero, b_lt, b_ltu, b_pe;
    logic [2:0]  a_op, b_op;
    logic [1:0]  a_jt, b_jt;
    logic        a_predf, b_predf, a_flush, b_flush;
    logic [1:0]  a_pcsrc, b_pcsrc;
`ifdef BRU_PERF_CNT_EN
    logic [31:0] a_bcnt, a_mcnt, b_bcnt, b_mcnt;
`endif

    branch_resolve_unit u_dut_a (
        .clk(clk), .rst(rst), .PCF(a_pcf), .PredTakenF(a_predf), .ValidE(a_valid),
        .StallE(a_stall), .PCE(a_pce), .BranchE(a_branch), .BranchOpE(a_op),
        .JumpTypeE(a_jt), .ZeroE(a_zero), .LtE(a_lt), .LtuE(a_ltu),
        .PredTakenE(a_pe), .PCSrcE(a_pcsrc),
`ifdef BRU_PERF_CNT_EN
        .BranchCntO(a_bcnt), .MispredCntO(a_mcnt),
`endif
        .FlushE(a_flush)
    );

    branch_resolve_unit #(.INDEX_MODE(1), .GHR_W(2)) u_dut_b (
        .clk(clk), .rst(rst), .PCF(b_pcf), .PredTakenF(b_predf), .ValidE(b_valid),
        .StallE(b_stall), .PCE(b_pce), .BranchE(b_branch), .BranchOpE(b_op),
        .JumpTypeE(b_jt), .ZeroE(b_zero), .LtE(b_lt), .LtuE(b_ltu),
        .PredTakenE(b_pe), .PCSrcE(b_pcsrc),
`ifdef BRU_PERF_CNT_EN
        .BranchCntO(b_bcnt), .MispredCntO(b_mcnt),
`endif
        .FlushE(b_flush)
    );

    typedef struct {
        int         id;
        bit         sel;
        logic [1:0] pcsrc;
        logic       flush;
        logic       predf;
        bit         chk_perf;
        logic [31:0] bcnt;
        logic [31:0] mcnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   perf_next = 1'b0;
    logic [31:0] perf_b = 32'd0;
    logic [31:0] perf_m = 32'd0;

    task automatic chk(input int id, input string what, input logic [31:0] got,
                       input logic [31:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL v%0d %s: got %0h expected %0h", id, what, got, expv);
        end
    endtask

    // Monitor: compare every queued expectation against the presented outputs.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.sel == 1'b0) begin
                chk(e.id, "pcsrc", {30'd0, a_pcsrc}, {30'd0, e.pcsrc});
                chk(e.id, "flush", {31'd0, a_flush}, {31'd0, e.flush});
                chk(e.id, "predf", {31'd0, a_predf}, {31'd0, e.predf});
            end else begin
                chk(e.id, "pcsrc", {30'd0, b_pcsrc}, {30'd0, e.pcsrc});
                chk(e.id, "flush", {31'd0, b_flush}, {31'd0, e.flush});
                chk(e.id, "predf", {31'd0, b_predf}, {31'd0, e.predf});
`ifdef BRU_PERF_CNT_EN
                if (e.chk_perf) begin
                    chk(e.id, "branch_cnt", b_bcnt, e.bcnt);
                    chk(e.id, "mispred_cnt", b_mcnt, e.mcnt);
                end
`endif
            end
        end
    end

    task automatic idle_all();
        a_valid = 1'b0; a_stall = 1'b0; a_pce = 32'd0; a_branch = 1'b0; a_op = 3'd0;
        a_jt = 2'd0; a_zero = 1'b0; a_lt = 1'b0; a_ltu = 1'b0; a_pe = 1'b0;
        b_valid = 1'b0; b_stall = 1'b0; b_pce = 32'd0; b_branch = 1'b0; b_op = 3'd0;
        b_jt = 2'd0; b_zero = 1'b0; b_lt = 1'b0; b_ltu = 1'b0; b_pe = 1'b0;
    endtask

    task automatic drv(input int id, input bit sel, input logic r, input logic v,
                       input logic s, input logic [31:0] pce, input logic br,
                       input logic [2:0] op, input logic [1:0] jt, input logic z,
                       input logic lt, input logic ltu, input logic pe,
                       input logic [31:0] pcf, input logic [1:0] e_src,
                       input logic e_fl, input logic e_pf);
        exp_t e;
        @(posedge clk);
        #1;
        idle_all();
        rst = r;
        if (sel == 1'b0) begin
            a_valid = v; a_stall = s; a_pce = pce; a_branch = br; a_op = op; a_jt = jt;
            a_zero = z; a_lt = lt; a_ltu = ltu; a_pe = pe; a_pcf = pcf;
        end else begin
            b_valid = v; b_stall = s; b_pce = pce; b_branch = br; b_op = op; b_jt = jt;
            b_zero = z; b_lt = lt; b_ltu = ltu; b_pe = pe; b_pcf = pcf;
        end
        e.id = id; e.sel = sel; e.pcsrc = e_src; e.flush = e_fl; e.predf = e_pf;
        e.chk_perf = perf_next; e.bcnt = perf_b; e.mcnt = perf_m;
        perf_next = 1'b0;
        exp_q.push_back(e);
    endtask

    // Bound the whole run.
    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        idle_all();
        a_pcf = 32'd0;
        b_pcf = 32'd0;
        // Bimodal: train counter[5] via BEQ at 0x14 (01 -> 10 -> 11 -> 11).
        drv(0,  0, 1'b1, 0, 0, 32'h00, 0, 3'b000, 2'b00, 0, 0, 0, 0, 32'h14, 2'b00, 0, 0);
        drv(1,  0, 1'b0, 1, 0, 32'h14, 1, 3'b000, 2'b00, 1, 0, 0, 0, 32'h14, 2'b01, 1, 0);
        drv(2,  0, 1'b0, 1, 0, 32'h14, 1, 3'b000, 2'b00, 1, 0, 0, 0, 32'h14, 2'b01, 1, 1);
        drv(3,  0, 1'b0, 1, 0, 32'h14, 1, 3'b000, 2'b00, 1, 0, 0, 0, 32'h14, 2'b01, 1, 1);
        drv(4,  0, 1'b0, 0, 0, 32'h00, 0, 3'b000, 2'b00, 0, 0, 0, 0, 32'h14, 2'b00, 0, 1);
        // BNE with ZeroE=1 predicted taken: recovery, counter 11 -> 10 -> 01.
        drv(5,  0, 1'b0, 1, 0, 32'h14, 1, 3'b001, 2'b00, 1, 0, 0, 1, 32'h14, 2'b11, 1, 1);
        drv(6,  0, 1'b0, 1, 0, 32'h14, 1, 3'b001, 2'b00, 1, 0, 0, 1, 32'h14, 2'b11, 1, 1);
        drv(7,  0, 1'b0, 0, 0, 32'h00, 0, 3'b000, 2'b00, 0, 0, 0, 0, 32'h14, 2'b00, 0, 0);
        // JALR with a taken BEQ alongside: jump wins, no training.
        drv(8,  0, 1'b0, 1, 0, 32'h14, 1, 3'b000, 2'b10, 1, 0, 0, 0, 32'h14, 2'b10, 1, 0);
        drv(9,  0, 1'b0, 0, 0, 32'h00, 0, 3'b000, 2'b00, 0, 0, 0, 0, 32'h14, 2'b00, 0, 0);
        // Stalled taken BEQ: outputs resolve, counter held.
        drv(10, 0, 1'b0, 1, 1, 32'h14, 1, 3'b000, 2'b00, 1, 0, 0, 1, 32'h14, 2'b00, 0, 0);
        drv(11, 0, 1'b0, 0, 0, 32'h00, 0, 3'b000, 2'b00, 0, 0, 0, 0, 32'h14, 2'b00, 0, 0);
        drv(12, 0, 1'b0, 1, 0, 32'h40, 0, 3'b000, 2'b01, 0, 0, 0, 0, 32'h14, 2'b01, 1, 0);
        // Remaining opcodes on counter[8] (PC 0x20).
        drv(13, 0, 1'b0, 1, 0, 32'h20, 1, 3'b100, 2'b00, 0, 1, 0, 1, 32'h20, 2'b00, 0, 0);
        drv(14, 0, 1'b0, 1, 0, 32'h20, 1, 3'b101, 2'b00, 0, 1, 0, 0, 32'h20, 2'b00, 0, 1);
        drv(15, 0, 1'b0, 1, 0, 32'h20, 1, 3'b110, 2'b00, 0, 0, 0, 1, 32'h20, 2'b11, 1, 0);
        drv(16, 0, 1'b0, 1, 0, 32'h20, 1, 3'b111, 2'b00, 0, 0, 0, 0, 32'h20, 2'b01, 1, 0);
        drv(17, 0, 1'b0, 1, 0, 32'h20, 1, 3'b010, 2'b00, 1, 1, 1, 1, 32'h20, 2'b11, 1, 0);
        // JumpType 11 behaves as none: the branch resolves and trains counter[12].
        drv(18, 0, 1'b0, 1, 0, 32'h30, 1, 3'b000, 2'b11, 1, 0, 0, 0, 32'h30, 2'b01, 1, 0);
        drv(19, 0, 1'b0, 0, 0, 32'h40, 0, 3'b000, 2'b01, 0, 0, 0, 0, 32'h30, 2'b00, 0, 1);
        // Retrain counter[5] to 11, then reset mid-run without a clock edge.
        drv(20, 0, 1'b0, 1, 0, 32'h14, 1, 3'b000, 2'b00, 1, 0, 0, 1, 32'h14, 2'b00, 0, 0);
        drv(21, 0, 1'b0, 1, 0, 32'h14, 1, 3'b000, 2'b00, 1, 0, 0, 1, 32'h14, 2'b00, 0, 1);
        drv(22, 0, 1'b0, 0, 0, 32'h00, 0, 3'b000, 2'b00, 0, 0, 0, 0, 32'h14, 2'b00, 0, 1);
        drv(23, 0, 1'b1, 1, 0, 32'h40, 0, 3'b000, 2'b01, 0, 0, 0, 0, 32'h14, 2'b01, 1, 0);
        drv(24, 0, 1'b0, 0, 0, 32'h00, 0, 3'b000, 2'b00, 0, 0, 0, 0, 32'h14, 2'b00, 0, 0);
        // Gshare: two taken branches both hash to idx 3; GHR ends at 11.
        drv(30, 1, 1'b0, 0, 0, 32'h00, 0, 3'b000, 2'b00, 0, 0, 0, 0, 32'h00, 2'b00, 0, 0);
        drv(31, 1, 1'b0, 1, 0, 32'h0C, 1, 3'b000, 2'b00, 1, 0, 0, 0, 32'h00, 2'b01, 1, 0);
        drv(32, 1, 1'b0, 1, 0, 32'h08, 1, 3'b000, 2'b00, 1, 0, 0, 0, 32'h00, 2'b01, 1, 0);
        perf_next = 1'b1;
        perf_b = 32'd2;
        perf_m = 32'd2;
        drv(33, 1, 1'b0, 0, 0, 32'h00, 0, 3'b000, 2'b00, 0, 0, 0, 0, 32'h00, 2'b00, 0, 1);
        drv(34, 1, 1'b0, 0, 0, 32'h00, 0, 3'b000, 2'b00, 0, 0, 0, 0, 32'h0C, 2'b00, 0, 0);
        @(negedge clk);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Execute-stage branch resolution unit with an integrated branch history table (BHT) for the pipelined RV32I core. It compares each branch's actual outcome against the prediction carried down the pipeline and produces the PC-select and flush controls. It also trains a parametrised table of 2-bit saturating counters, indexed bimodally or gshare-style. A combinational lookup port supplies the front end with a taken/not-taken prediction for the fetch PC.

## Interface
- XLEN, 32, PC width
- BHT_ENTRIES, 64, counter count; power of two, ≥4
- INDEX_MODE, 0, 0 = bimodal (PC bits), 1 = gshare (PC bits XOR GHR)
- GHR_W, 6, global history length; must be ≤ log2(BHT_ENTRIES); used only when INDEX_MODE=1
- CNT_W, 32, perf counter width (BRU_PERF_CNT_EN only)

- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- PCF  in  XLEN  fetch PC for lookup
- PredTakenF  out  1  prediction for PCF
- ValidE  in  1  execute slot holds a real instruction
- StallE  in  1  execute stage held this cycle
- PCE  in  XLEN  PC of the execute instruction
- BranchE  in  1  conditional branch
- BranchOpE  in  3  funct3: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU
- JumpTypeE  in  2  00 none, 01 JAL, 10 JALR, 11 treated as none
- ZeroE, LtE, LtuE  in  1 each  ALU flags: equal, signed less-than, unsigned less-than
- PredTakenE  in  1  PredTakenF value piped with the instruction
- PCSrcE  out  2  00 sequential, 01 branch/JAL target, 10 JALR ALU result, 11 PCE+4 recovery
- FlushE  out  1  redirect: flush the fetch and decode stages
- BranchCntO, MispredCntO  out  CNT_W  perf counters (BRU_PERF_CNT_EN only)

## Operation
- Index computation:
  - idx = PC[log2(BHT_ENTRIES)+1:2].
  - In gshare mode, the low GHR_W bits of idx are XORed with the GHR.
  - The same function applies to PCF (lookup) and PCE (update).
- PredTakenF = MSB of counter[idx(PCF)].
- Taken condition, by BranchOpE:
  - BEQ: ZeroE; BNE: !ZeroE
  - BLT: LtE; BGE: !LtE
  - BLTU: LtuE; BGEU: !LtuE
  - Undefined opcodes (010, 011): not taken.
- Resolution, evaluated in priority order:
  1. !ValidE → PCSrcE=00, FlushE=0.
  2. JumpTypeE=01 → PCSrcE=01, FlushE=1.
  3. JumpTypeE=10 → PCSrcE=10, FlushE=1. Jumps win over BranchE.
  4. BranchE:
     - taken & pred → 00, no flush
     - taken & !pred → 01, flush
     - !taken & pred → 11, flush
     - !taken & !pred → 00, no flush
  5. Otherwise → 00, no flush.
- Update enable is ValidE & BranchE & JumpTypeE∉{01,10} & !StallE. When enabled:
  - Counter at idx(PCE): saturating increment if taken, decrement if not; 11 and 00 saturate.
  - GHR ← {GHR[GHR_W-2:0], taken}.
- Jumps do not train the BHT or the GHR.
- Undefined encodings never halt simulation; behaviour is deterministic as listed above.

## Timing
- PCSrcE, FlushE, PredTakenF: combinational, zero latency.
- BHT and GHR writes land at the rising edge, visible to PredTakenF from the next cycle.
- Same-cycle lookup and update of the same index: lookup returns the pre-update value (no bypass).
- StallE=1 holds all state; the outputs still reflect the current inputs.
- Reset, asserted at any time, immediately forces:
  - every counter to 01 (weakly not-taken), so PredTakenF=0
  - GHR to 0
  - perf counters to 0
- PCSrcE and FlushE stay purely input-driven; no reset dependency.

## Configuration
- BRU_PERF_CNT_EN defined:
  - BranchCntO increments on every update-enable cycle.
  - MispredCntO increments on every update-enable cycle with FlushE=1.
  - Both wrap modulo 2^CNT_W.
- BRU_PERF_CNT_EN undefined: the counters and ports are absent; all other behaviour is identical.

## Structure
- Package bru_pkg holds:
  - enums for PCSrc encodings (PCSRC_SEQ, PCSRC_TGT, PCSRC_JALR, PCSRC_RECOV), BranchOp and JumpType
  - the counter reset constant 2'b01
- Sub-module bht_table holds the counter array: one combinational read port, one write port with saturating update logic, asynchronous reset.
- Index hashing and GHR live in branch_resolve_unit.

## Test plan
- Reset mid-run after training counter[5] to 11 → counter reads 01 and PredTakenF=0 with no clock edge.
- BEQ at PCE=0x14 (ZeroE=1, PredTakenE=0), three times → PCSrcE=01 and FlushE=1 each time; PredTakenF for PCF=0x14 becomes 1 after the first update (01→10) and saturates at 11.
- BNE, ZeroE=1, PredTakenE=1 → PCSrcE=11, FlushE=1; counter decrements.
- JALR with BranchE=1 → PCSrcE=10, FlushE=1; BHT and GHR unchanged.
- StallE=1 on a taken BEQ → outputs resolve normally; counter unchanged.
- INDEX_MODE=1, GHR_W=2, two taken branches → GHR=11; PCF=0x00 reads idx 3. With BRU_PERF_CNT_EN defined, BranchCntO=2.
